// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    // Receiver frame FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam int         PS2_EVENT_W    = 10;

    // A frame is good when start is 0, stop is 1 and data+parity hold an odd number of ones.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
        return (frame[0] == 1'b0) && (frame[PS2_FRAME_BITS-1] == 1'b1) && (^frame[9:1]);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy, full/empty and overflow pulse.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer bookkeeping and the dropped-event pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are only visible through dout while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisers, clock deglitch filter, frame FSM with
// watchdog, E0/F0 prefix folding and an event FIFO towards the consumer.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 125000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rx_en,
    input  logic                          rd_en,
    output logic [PS2_EVENT_W-1:0]        dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          timeout,
    output logic                          overflow
);

    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [1:0]                c_sync;
    logic [1:0]                d_sync;
    logic                      fc;
    logic [FC_W-1:0]           filt_cnt;
    logic                      fall;
    logic                      fall_bit;

    rx_state_t                 state;
    logic [PS2_FRAME_BITS-1:0] shift_reg;
    logic [3:0]                bit_cnt;
    logic [WD_W-1:0]           wd_cnt;
    logic                      take;
    logic                      ext;
    logic                      brk;

    logic                      frame_valid;
    logic [7:0]                rx_byte;
    logic                      push;
    logic [PS2_EVENT_W-1:0]    push_data;

    // Two-flop synchronisers; both pins idle high on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
        end
    end

    // Clock filter: fc follows only after FILTER_LEN agreeing samples; a falling fc strobes the data bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fc       <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            fall_bit <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (c_sync[1] == fc) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FC_LAST) begin
                fc       <= c_sync[1];
                filt_cnt <= '0;
                fall     <= fc;
                fall_bit <= d_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign frame_valid = ps2_frame_ok(shift_reg);
    assign rx_byte     = shift_reg[8:1];
    assign push        = (state == ST_CHECK) && frame_valid && take &&
                         (rx_byte != PS2_EXT) && (rx_byte != PS2_BRK);
    assign push_data   = {brk, ext, rx_byte};

    // Frame FSM: collect 11 bits LSB first, watchdog mid-frame, then validate and fold prefixes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            wd_cnt    <= '0;
            take      <= 1'b0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (fall) begin
                        shift_reg <= {fall_bit, {(PS2_FRAME_BITS-1){1'b0}}};
                        take      <= rx_en;
                        bit_cnt   <= 4'd1;
                        state     <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (fall) begin
                        shift_reg <= {fall_bit, shift_reg[PS2_FRAME_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                        wd_cnt    <= '0;
                        if (bit_cnt == LAST_BIT) state <= ST_CHECK;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout <= 1'b1;
                        ext     <= 1'b0;
                        brk     <= 1'b0;
                        wd_cnt  <= '0;
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    if (!frame_valid) begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end else if (take) begin
                        if (rx_byte == PS2_EXT) begin
                            ext <= 1'b1;
                        end else if (rx_byte == PS2_BRK) begin
                            brk <= 1'b1;
                        end else begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVENT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (rd_en),
        .din      (push_data),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, expected events queued at issue time.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int FIFO_DEPTH     = 4;

    logic                          clk;
    logic                          reset;
    logic                          ps2c;
    logic                          ps2d;
    logic                          rx_en;
    logic                          rd_en;
    logic [9:0]                    dout;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          frame_err;
    logic                          timeout;
    logic                          overflow;

    int checks;
    int errors;
    int ferr_seen, tmo_seen, ovf_seen;
    int ferr_exp, tmo_exp, ovf_exp;
    logic [9:0] sb[$];

    ps2_keyboard_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .rx_en     (rx_en),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err),
        .timeout   (timeout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send nbits of a PS/2 frame for data; optional bad parity, clock glitches, or a pop aligned to the push.
    task automatic applyStimulus(input logic [7:0] data, input bit bad_par, input bit glitch,
                                 input bit pop_at_push, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^data) ^ bad_par, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            waitClk(10);
            ps2c = 1'b0;
            if (glitch) begin
                waitClk(8);  ps2c = 1'b1;
                waitClk(1);  ps2c = 1'b0;
                waitClk(11);
            end else if (pop_at_push && i == 10) begin
                waitClk(7);  rd_en = 1'b1;
                waitClk(1);  rd_en = 1'b0;
                waitClk(12);
            end else begin
                waitClk(20);
            end
            ps2c = 1'b1;
            if (glitch) begin
                waitClk(7);  ps2c = 1'b0;
                waitClk(1);  ps2c = 1'b1;
                waitClk(2);
            end else begin
                waitClk(10);
            end
        end
        ps2d = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] data);
        applyStimulus(data, 1'b0, 1'b0, 1'b0, 11);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (empty == 1'b0 && guard < 4 * FIFO_DEPTH) begin
            rd_en = 1'b1;
            waitClk(1);
            guard++;
        end
        rd_en = 1'b0;
        checkOutput("drain_empty", empty, 1'b1);
    endtask

    task automatic checkPulses(input string tag);
        checkOutput({tag, "_frame_err"}, ferr_seen, ferr_exp);
        checkOutput({tag, "_timeout"},   tmo_seen,  tmo_exp);
        checkOutput({tag, "_overflow"},  ovf_seen,  ovf_exp);
    endtask

    // Monitor: every accepted pop is compared against the oldest expected event.
    always @(negedge clk) begin
        if (reset && rd_en && !empty) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event actual=%0h expected=none", dout);
            end else begin
                checkOutput("event", dout, sb.pop_front());
            end
        end
    end

    // Pulse monitor: counts high cycles so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) ferr_seen++;
            if (timeout)   tmo_seen++;
            if (overflow)  ovf_seen++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        checks = 0; errors = 0;
        ferr_seen = 0; tmo_seen = 0; ovf_seen = 0;
        ferr_exp = 0; tmo_exp = 0; ovf_exp = 0;
        ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0; reset = 1'b0;

        waitClk(3);
        checkOutput("rst_dout",  dout,  10'h000);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full",  full,  1'b0);
        checkOutput("rst_count", count, 0);
        reset = 1'b1;
        waitClk(5);

        $display("[TB] single make code 1C");
        sb.push_back(10'h01C);
        sendByte(8'h1C);
        waitClk(20);
        checkOutput("s1_count", count, 1);
        checkOutput("s1_empty", empty, 1'b0);
        checkOutput("s1_dout",  dout,  10'h01C);
        drain();

        $display("[TB] prefixed sequences");
        sb.push_back(10'h375);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        sb.push_back(10'h21C);
        sendByte(8'hF0); sendByte(8'h1C);
        waitClk(20);
        checkOutput("s2_count", count, 2);
        checkOutput("s2_head",  dout,  10'h375);
        drain();

        $display("[TB] parity errors");
        applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0, 11);
        ferr_exp++;
        waitClk(20);
        checkOutput("s3_empty", empty, 1'b1);
        sendByte(8'hF0);
        applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0, 11);
        ferr_exp++;
        sb.push_back(10'h01C);
        sendByte(8'h1C);
        waitClk(20);
        drain();
        checkPulses("s3");

        $display("[TB] watchdog");
        sendByte(8'hF0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 5);
        waitClk(TIMEOUT_CYCLES + 60);
        tmo_exp++;
        checkPulses("s4");
        checkOutput("s4_empty", empty, 1'b1);
        sb.push_back(10'h029);
        sendByte(8'h29);
        waitClk(20);
        drain();

        $display("[TB] fill and overflow");
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            if (i < FIFO_DEPTH) sb.push_back(10'h011 + 10'(i));
            sendByte(8'h11 + 8'(i));
        end
        ovf_exp++;
        waitClk(20);
        checkOutput("s5_full",  full,  1'b1);
        checkOutput("s5_count", count, FIFO_DEPTH);
        checkOutput("s5_head",  dout,  10'h011);
        checkPulses("s5a");
        sb.push_back(10'h016);
        applyStimulus(8'h16, 1'b0, 1'b0, 1'b1, 11);
        waitClk(20);
        checkOutput("s5_full2",  full,  1'b1);
        checkOutput("s5_count2", count, FIFO_DEPTH);
        checkOutput("s5_head2",  dout,  10'h012);
        checkPulses("s5b");
        drain();

        $display("[TB] glitched clock");
        sb.push_back(10'h05A);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0, 11);
        waitClk(20);
        checkOutput("s6_dout", dout, 10'h05A);
        drain();
        checkPulses("s6");

        $display("[TB] receive disabled");
        rx_en = 1'b0;
        sendByte(8'h1C);
        rx_en = 1'b1;
        waitClk(20);
        checkOutput("s7_empty", empty, 1'b1);
        checkPulses("s7");

        $display("[TB] reset mid-frame");
        sendByte(8'h33);
        waitClk(20);
        checkOutput("s8_pre_count", count, 1);
        applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0, 4);
        reset = 1'b0;
        waitClk(2);
        checkOutput("s8_dout",      dout,      10'h000);
        checkOutput("s8_empty",     empty,     1'b1);
        checkOutput("s8_full",      full,      1'b0);
        checkOutput("s8_count",     count,     0);
        checkOutput("s8_frame_err", frame_err, 1'b0);
        checkOutput("s8_timeout",   timeout,   1'b0);
        checkOutput("s8_overflow",  overflow,  1'b0);
        reset = 1'b1;
        waitClk(5);
        sb.push_back(10'h044);
        sendByte(8'h44);
        waitClk(20);
        drain();
        checkPulses("s8");
        checkOutput("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
